// File: rtl/cva5_types.sv
// Shared types for the return-address stack: checkpoint layout and stack-op encoding.
// RAS_DEPTH sets the pointer/count widths and must equal the stack's DEPTH parameter.
package cva5_types;

    localparam int RAS_DEPTH = 8;
    localparam int RAS_PTR_W = $clog2(RAS_DEPTH);
    localparam int RAS_CNT_W = RAS_PTR_W + 1;

    typedef struct packed {
        logic [RAS_PTR_W-1:0] wr_ptr;
        logic [RAS_CNT_W-1:0] count;
    } ras_checkpoint_t;

    typedef enum logic [1:0] {
        RAS_HOLD,
        RAS_PUSH,
        RAS_POP,
        RAS_REPLACE
    } ras_op_e;

    // A push onto a full stack overwrites the oldest slot, so occupancy stops at DEPTH.
    function automatic logic [RAS_CNT_W-1:0] ras_count_inc(input logic [RAS_CNT_W-1:0] cnt);
        return (cnt == RAS_CNT_W'(RAS_DEPTH)) ? cnt : cnt + RAS_CNT_W'(1);
    endfunction

endpackage

// File: rtl/ras_checkpoint_fifo.sv
// In-order queue of stack-pointer checkpoints, one per in-flight predicted branch.
// A push into a full queue is accepted only when a pop frees a slot in the same cycle.
module ras_checkpoint_fifo
    import cva5_types::*;
#(
    parameter int CKPT_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            clear,
    input  ras_checkpoint_t data_in,
    output ras_checkpoint_t data_out,
    output logic            empty,
    output logic            full
);
    localparam int IDX_W = $clog2(CKPT_DEPTH);
    localparam logic [IDX_W:0]   OCC_FULL = (IDX_W+1)'(CKPT_DEPTH);
    localparam logic [IDX_W:0]   OCC_ONE  = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    ras_checkpoint_t entries [CKPT_DEPTH];

    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [IDX_W:0]   occ_q, occ_d;
    logic             do_push, do_pop;

    assign empty    = (occ_q == '0);
    assign full     = (occ_q == OCC_FULL);
    assign do_pop   = pop && !empty && !clear;
    assign do_push  = push && (!full || do_pop) && !clear;
    assign data_out = entries[head_q];

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (clear) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end else begin
            if (do_push) tail_d = tail_q + IDX_ONE;
            if (do_pop)  head_d = head_q + IDX_ONE;
            if (do_push && !do_pop)      occ_d = occ_q + OCC_ONE;
            else if (do_pop && !do_push) occ_d = occ_q - OCC_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) entries[tail_q] <= data_in;
    end

endmodule

// File: rtl/return_address_stack.sv
// Speculative return-address stack with circular overwrite on overflow.
// Define RAS_RECOVERY_EN to build the checkpoint queue that restores the pointer on early flush.
module return_address_stack
    import cva5_types::*;
#(
    parameter int DEPTH      = RAS_DEPTH,
    parameter int ADDR_W     = 32,
    parameter int CKPT_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] new_addr,
    output logic [ADDR_W-1:0] addr,
    output logic              valid,
    input  logic              branch_fetched,
    input  logic              branch_retired,
    input  logic              early_branch_flush,
    output logic              ckpt_full
);
    localparam logic [RAS_PTR_W-1:0] PTR_ONE = RAS_PTR_W'(1);
    localparam logic [RAS_CNT_W-1:0] CNT_ONE = RAS_CNT_W'(1);

    logic [ADDR_W-1:0]    stack_mem [DEPTH];
    logic [RAS_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [RAS_CNT_W-1:0] count_q, count_d;
    logic [RAS_PTR_W-1:0] top_ptr, upd_ptr, mem_waddr;
    logic [RAS_CNT_W-1:0] upd_count;
    logic                 mem_we;
    ras_op_e              op;
    logic                 restore_en;
    ras_checkpoint_t      restore_val;

    assign top_ptr = wr_ptr_q - PTR_ONE;
    assign addr    = stack_mem[top_ptr];
    assign valid   = (count_q != '0);

    // A flush cycle discards the fetch-side push/pop; popping an empty stack is a no-op.
    always_comb begin
        op = RAS_HOLD;
        if (!early_branch_flush) begin
            if (push && pop)    op = RAS_REPLACE;
            else if (push)      op = RAS_PUSH;
            else if (pop && valid) op = RAS_POP;
        end
    end

    always_comb begin
        upd_ptr   = wr_ptr_q;
        upd_count = count_q;
        mem_we    = 1'b0;
        mem_waddr = wr_ptr_q;
        unique case (op)
            RAS_HOLD: ;
            RAS_PUSH: begin
                mem_we    = 1'b1;
                upd_ptr   = wr_ptr_q + PTR_ONE;
                upd_count = ras_count_inc(count_q);
            end
            RAS_POP: begin
                upd_ptr   = top_ptr;
                upd_count = count_q - CNT_ONE;
            end
            RAS_REPLACE: begin
                mem_we    = 1'b1;
                mem_waddr = top_ptr;
                if (!valid) upd_count = CNT_ONE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = upd_ptr;
        count_d  = upd_count;
        if (restore_en) begin
            wr_ptr_d = restore_val.wr_ptr;
            count_d  = restore_val.count;
        end
    end

`ifdef RAS_RECOVERY_EN
    ras_checkpoint_t ckpt_snap;
    logic            ckpt_push, ckpt_pop, ckpt_empty;

    // Snapshot reflects this cycle's push/pop so a restore lands just after the branch.
    assign ckpt_snap  = '{wr_ptr: upd_ptr, count: upd_count};
    assign ckpt_push  = branch_fetched && !early_branch_flush;
    assign ckpt_pop   = branch_retired && !early_branch_flush;
    assign restore_en = early_branch_flush && !ckpt_empty;

    ras_checkpoint_fifo #(
        .CKPT_DEPTH(CKPT_DEPTH)
    ) u_ckpt_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (ckpt_push),
        .pop      (ckpt_pop),
        .clear    (early_branch_flush),
        .data_in  (ckpt_snap),
        .data_out (restore_val),
        .empty    (ckpt_empty),
        .full     (ckpt_full)
    );
`else
    localparam int unused_ckpt_depth = CKPT_DEPTH;
    logic unused_branch;

    assign unused_branch = branch_fetched ^ branch_retired;
    assign restore_en    = 1'b0;
    assign restore_val   = '0;
    assign ckpt_full     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) stack_mem[mem_waddr] <= new_addr;
    end

endmodule

// File: tb/tb_return_address_stack.sv
// Scoreboard bench for return_address_stack; expectations follow RAS_RECOVERY_EN if defined.
module tb_return_address_stack;
`ifdef RAS_RECOVERY_EN
    localparam bit REC = 1'b1;
`else
    localparam bit REC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push = 1'b0, pop = 1'b0;
    logic [31:0] new_addr = '0;
    logic [31:0] addr;
    logic        valid, ckpt_full;
    logic        branch_fetched = 1'b0, branch_retired = 1'b0, early_branch_flush = 1'b0;

    typedef struct { string tag; logic vld; logic [31:0] a; logic [3:0] cnt; logic full; bit ca; } exp_t;
    typedef struct { logic vld; logic [31:0] a; logic [3:0] cnt; logic full; } obs_t;

    exp_t sbq[$];
    obs_t obq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    return_address_stack #(.DEPTH(8), .ADDR_W(32), .CKPT_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .new_addr(new_addr),
        .addr(addr), .valid(valid), .branch_fetched(branch_fetched),
        .branch_retired(branch_retired), .early_branch_flush(early_branch_flush),
        .ckpt_full(ckpt_full)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst && branch_fetched && ckpt_full && !branch_retired)
            $error("branch_fetched issued while checkpoint queue full");
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "timeout");
    end

    function automatic exp_t mk(string tag, logic vld, logic [31:0] a, int cnt, logic full, bit ca);
        exp_t e;
        e.tag = tag; e.vld = vld; e.a = a; e.cnt = 4'(cnt); e.full = full; e.ca = ca;
        return e;
    endfunction

    task automatic step(input logic p, input logic po, input logic [31:0] a,
                        input logic bf, input logic br, input logic fl, input exp_t e);
        obs_t o;
        push = p; pop = po; new_addr = a;
        branch_fetched = bf; branch_retired = br; early_branch_flush = fl;
        sbq.push_back(e);
        @(posedge clk); #1;
        o.vld = valid; o.a = addr; o.cnt = dut.count_q; o.full = ckpt_full;
        obq.push_back(o);
        push = 0; pop = 0; new_addr = '0;
        branch_fetched = 0; branch_retired = 0; early_branch_flush = 0;
    endtask

    task automatic test_reset();
        exp_t e; obs_t o;
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if (valid !== 1'b0 || ckpt_full !== 1'b0 || dut.count_q !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got valid=%b full=%b count=%0d, want valid=0 full=0 count=0",
                     valid, ckpt_full, dut.count_q);
        end
        @(negedge clk) rst = 1'b1;
        step(0, 0, 0, 0, 0, 0, mk("reset_idle", 0, 0, 0, 0, 0));
        while (sbq.size() > 0) begin
            e = sbq.pop_front(); o = obq.pop_front(); n_tests++;
            if (o.vld !== e.vld || o.cnt !== e.cnt || o.full !== e.full || (e.ca && o.a !== e.a)) begin
                n_fail++;
                $display("FAIL %s: got valid=%b addr=%h count=%0d full=%b, want valid=%b addr=%h count=%0d full=%b",
                         e.tag, o.vld, o.a, o.cnt, o.full, e.vld, e.a, e.cnt, e.full);
            end
        end
    endtask

    task automatic test_fill_overflow();
        exp_t e; obs_t o;
        for (int i = 1; i <= 9; i++)
            step(1, 0, 32'(i * 'h100), 0, 0, 0, mk("fill_push", 1, 32'(i * 'h100), (i > 8) ? 8 : i, 0, 1));
        for (int k = 1; k <= 7; k++)
            step(0, 1, 0, 0, 0, 0, mk("drain_pop", 1, 32'('h900 - k * 'h100), 8 - k, 0, 1));
        step(0, 1, 0, 0, 0, 0, mk("drain_wrapped", 0, 32'h900, 0, 0, 1));
        step(0, 1, 0, 0, 0, 0, mk("drain_ninth", 0, 32'h900, 0, 0, 1));
        while (sbq.size() > 0) begin
            e = sbq.pop_front(); o = obq.pop_front(); n_tests++;
            if (o.vld !== e.vld || o.cnt !== e.cnt || o.full !== e.full || (e.ca && o.a !== e.a)) begin
                n_fail++;
                $display("FAIL %s: got valid=%b addr=%h count=%0d full=%b, want valid=%b addr=%h count=%0d full=%b",
                         e.tag, o.vld, o.a, o.cnt, o.full, e.vld, e.a, e.cnt, e.full);
            end
        end
    endtask

    task automatic test_underflow();
        exp_t e; obs_t o;
        step(0, 1, 0, 0, 0, 0, mk("underflow_pop", 0, 32'h900, 0, 0, 1));
        step(1, 0, 32'h40, 0, 0, 0, mk("underflow_push", 1, 32'h40, 1, 0, 1));
        step(0, 1, 0, 0, 0, 0, mk("underflow_empty", 0, 0, 0, 0, 0));
        while (sbq.size() > 0) begin
            e = sbq.pop_front(); o = obq.pop_front(); n_tests++;
            if (o.vld !== e.vld || o.cnt !== e.cnt || o.full !== e.full || (e.ca && o.a !== e.a)) begin
                n_fail++;
                $display("FAIL %s: got valid=%b addr=%h count=%0d full=%b, want valid=%b addr=%h count=%0d full=%b",
                         e.tag, o.vld, o.a, o.cnt, o.full, e.vld, e.a, e.cnt, e.full);
            end
        end
    endtask

    task automatic test_push_pop();
        exp_t e; obs_t o;
        step(1, 0, 32'h10, 0, 0, 0, mk("pp_push1", 1, 32'h10, 1, 0, 1));
        step(1, 0, 32'h20, 0, 0, 0, mk("pp_push2", 1, 32'h20, 2, 0, 1));
        step(1, 1, 32'h30, 0, 0, 0, mk("pp_replace", 1, 32'h30, 2, 0, 1));
        step(0, 1, 0, 0, 0, 0, mk("pp_pop_below", 1, 32'h10, 1, 0, 1));
        step(0, 1, 0, 0, 0, 0, mk("pp_pop_empty", 0, 0, 0, 0, 0));
        step(1, 1, 32'h30, 0, 0, 0, mk("pp_replace_empty", 1, 32'h30, 1, 0, 1));
        step(0, 1, 0, 0, 0, 0, mk("pp_cleanup", 0, 0, 0, 0, 0));
        while (sbq.size() > 0) begin
            e = sbq.pop_front(); o = obq.pop_front(); n_tests++;
            if (o.vld !== e.vld || o.cnt !== e.cnt || o.full !== e.full || (e.ca && o.a !== e.a)) begin
                n_fail++;
                $display("FAIL %s: got valid=%b addr=%h count=%0d full=%b, want valid=%b addr=%h count=%0d full=%b",
                         e.tag, o.vld, o.a, o.cnt, o.full, e.vld, e.a, e.cnt, e.full);
            end
        end
    endtask

    task automatic test_flush_restore();
        exp_t e; obs_t o;
        step(1, 0, 32'h10, 1, 0, 0, mk("fl_push_ckpt", 1, 32'h10, 1, 0, 1));
        step(1, 0, 32'h20, 0, 0, 0, mk("fl_push2", 1, 32'h20, 2, 0, 1));
        step(1, 0, 32'h30, 0, 0, 0, mk("fl_push3", 1, 32'h30, 3, 0, 1));
        step(1, 0, 32'h55, 0, 0, 1, mk("fl_flush", 1, REC ? 32'h10 : 32'h30, REC ? 1 : 3, 0, 1));
        step(0, 0, 0, 0, 0, 1, mk("fl_reflush", 1, REC ? 32'h10 : 32'h30, REC ? 1 : 3, 0, 1));
        while (sbq.size() > 0) begin
            e = sbq.pop_front(); o = obq.pop_front(); n_tests++;
            if (o.vld !== e.vld || o.cnt !== e.cnt || o.full !== e.full || (e.ca && o.a !== e.a)) begin
                n_fail++;
                $display("FAIL %s: got valid=%b addr=%h count=%0d full=%b, want valid=%b addr=%h count=%0d full=%b",
                         e.tag, o.vld, o.a, o.cnt, o.full, e.vld, e.a, e.cnt, e.full);
            end
        end
    endtask

    task automatic test_queue_limits();
        exp_t e; obs_t o;
        int c0;
        logic [31:0] t0;
        c0 = REC ? 1 : 3;
        t0 = REC ? 32'h10 : 32'h30;
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 1, 0, 0, mk("q_fetch", 1, t0, c0, 0, 1));
        step(0, 0, 0, 1, 0, 0, mk("q_fetch_full", 1, t0, c0, REC, 1));
        step(0, 0, 0, 1, 1, 0, mk("q_fetch_retire_full", 1, t0, c0, REC, 1));
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 0, 1, 0, mk("q_retire", 1, t0, c0, 0, 1));
        step(0, 0, 0, 0, 1, 0, mk("q_retire_empty", 1, t0, c0, 0, 1));
        step(1, 0, 32'h66, 0, 0, 0, mk("q_push66", 1, 32'h66, c0 + 1, 0, 1));
        step(0, 0, 0, 0, 0, 1, mk("q_flush_empty", 1, 32'h66, c0 + 1, 0, 1));
        step(1, 0, 32'h70, 1, 0, 0, mk("q_push70_ckpt", 1, 32'h70, c0 + 2, 0, 1));
        step(1, 0, 32'h71, 0, 0, 0, mk("q_push71", 1, 32'h71, c0 + 3, 0, 1));
        step(0, 0, 0, 0, 0, 1, mk("q_flush_restore", 1, REC ? 32'h70 : 32'h71, REC ? c0 + 2 : c0 + 3, 0, 1));
        while (sbq.size() > 0) begin
            e = sbq.pop_front(); o = obq.pop_front(); n_tests++;
            if (o.vld !== e.vld || o.cnt !== e.cnt || o.full !== e.full || (e.ca && o.a !== e.a)) begin
                n_fail++;
                $display("FAIL %s: got valid=%b addr=%h count=%0d full=%b, want valid=%b addr=%h count=%0d full=%b",
                         e.tag, o.vld, o.a, o.cnt, o.full, e.vld, e.a, e.cnt, e.full);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e; obs_t o;
        step(1, 0, 32'h11, 1, 0, 0, mk("ar_push", 1, 32'h11, REC ? 4 : 7, 0, 1));
        #3 rst = 1'b0;
        #1;
        n_tests++;
        if (valid !== 1'b0 || dut.count_q !== 4'd0 || ckpt_full !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got valid=%b count=%0d full=%b, want valid=0 count=0 full=0",
                     valid, dut.count_q, ckpt_full);
        end
        #3 rst = 1'b1;
        step(1, 0, 32'h44, 0, 0, 0, mk("ar_first_push", 1, 32'h44, 1, 0, 1));
        step(0, 0, 0, 0, 0, 1, mk("ar_flush_after", 1, 32'h44, 1, 0, 1));
        while (sbq.size() > 0) begin
            e = sbq.pop_front(); o = obq.pop_front(); n_tests++;
            if (o.vld !== e.vld || o.cnt !== e.cnt || o.full !== e.full || (e.ca && o.a !== e.a)) begin
                n_fail++;
                $display("FAIL %s: got valid=%b addr=%h count=%0d full=%b, want valid=%b addr=%h count=%0d full=%b",
                         e.tag, o.vld, o.a, o.cnt, o.full, e.vld, e.a, e.cnt, e.full);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_underflow();
        test_push_pop();
        test_flush_restore();
        test_queue_limits();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
